// File: rtl/sn74ls175_sertx_if.sv
// Bus bundle for the sn74ls175 serial transmitter: load strobe and data in,
// then the captured word, serial line and status out.
interface sn74ls175_sertx_if #(
  parameter int WIDTH = 4
);
  logic             ld;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             so;
  logic             so_;
  logic             busy;
  logic             done;

  modport master (
    output ld, d,
    input  q, so, so_, busy, done
  );

  modport slave (
    input  ld, d,
    output q, so, so_, busy, done
  );
endinterface

// File: rtl/sn74ls175_sertx.sv
// Parallel-load, serial-out framer: captures a word on ld and sends
// a start bit, WIDTH data bits and a stop bit, each DIV clocks long.
module sn74ls175_sertx #(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              clr,
  sn74ls175_sertx_if.slave  bus
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             so_q, so_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_last_s;

  function automatic logic head_bit(input logic [WIDTH-1:0] s);
    return (MSB_FIRST != 0) ? s[WIDTH-1] : s[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] s);
    return (MSB_FIRST != 0) ? (s << 1) : (s >> 1);
  endfunction

  assign div_last_s = (div_q == DIV_LAST);

  // Next-state and output decode for the frame sequencer.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    div_d   = div_q;
    so_d    = so_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Ternaries keep an unknown ld visible on q, so and busy.
        q_d    = bus.ld ? bus.d : q_q;
        sh_d   = bus.ld ? bus.d : sh_q;
        busy_d = bus.ld ? 1'b1 : 1'b0;
        so_d   = bus.ld ? 1'b0 : 1'b1;
        bit_d  = '0;
        div_d  = '0;
        if (bus.ld) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (div_last_s) begin
          state_d = DATA;
          so_d    = head_bit(sh_q);
          sh_d    = shift_out(sh_q);
          bit_d   = '0;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (div_last_s) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            so_d    = 1'b1;
          end else begin
            so_d  = head_bit(sh_q);
            sh_d  = shift_out(sh_q);
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (div_last_s) begin
          state_d = IDLE;
          so_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        so_d    = 1'b1;
        busy_d  = 1'b0;
        bit_d   = '0;
        div_d   = '0;
      end
    endcase
  end

  // State and output registers; clr clears everything without a clock.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      q_q     <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      so_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      so_q    <= so_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.so   = so_q;
  assign bus.so_  = ~so_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/sn74ls175_sertx.md
Name: sn74ls175_sertx

Overview:
Parallel-load, serial-out transmitter that drains a 4-bit register word such as an sn74ls175 q bus.
- Captures the word on a load strobe and emits one framed serial character: start bit, data bits, stop bit.
- Provides busy/done status for the upstream writer.
- Simulatable TTL-flavour model for the device library, used wherever latched register contents must be shipped serially.

Parameters:
- WIDTH, 4, number of data bits per frame.
- DIV, 1, clocks per serial bit (must be >= 1).
- MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr  input  1  asynchronous, active-high reset.
- ld  input  1  load strobe, sampled on the rising clk edge.
- d  input  WIDTH  parallel data word.
- q  output  WIDTH  holding register (captured word), readback.
- so  output  1  serial data out; idle level 1.
- so_  output  1  always the complement of so.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-clock pulse at frame completion.

Behaviour:
- Reset: clr=1 forces, immediately and without a clock:
  - q=0, so=1, so_=0, busy=0, done=0
  - state=IDLE, bit counter=0, divider counter=0
- Reset during a frame aborts it; no done pulse; so returns to 1 at once. While clr=1, ld is ignored.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - so=1.
  - On a rising edge with ld=1: q<=d, busy<=1, state<=START, so<=0.
  - ld=0 holds all state.
- START:
  - so=0 for DIV clocks, then DATA.
  - The first data bit appears on so at the edge ending START.
- DATA:
  - WIDTH bits, each held for DIV clocks.
  - Order: MSB_FIRST=1 gives q[WIDTH-1] first; MSB_FIRST=0 gives q[0] first.
  - Shifting uses an internal copy; q stays stable for the whole frame.
- STOP:
  - so=1 for DIV clocks.
  - At the edge ending STOP: busy<=0, done<=1, state<=IDLE.
- done is high for exactly one clock, then clears.
- Frame length: (WIDTH+2)*DIV clocks, from the edge accepting ld to the edge clearing busy.
- ld while busy=1 is ignored, including ld sampled on the edge that clears busy. The next frame is accepted no earlier than the following edge, when busy=0.
- Back-to-back frames: ld held continuously produces frames separated by exactly one IDLE clock (so=1 in that clock).
- Unknown inputs: x/z on d is captured as-is and propagates to q and so. ld=x in IDLE drives q, so and busy to x (pessimistic model).
- so_ is continuously ~so, including across reset.

Test Plan:
- Reset and idle: clr=1 with clk and d = x -> q=0000, so=1, so_=0, busy=0, done=0. Release clr with ld=0 for 5 clocks -> no change.
- Load 1010, defaults (WIDTH=4, DIV=1, MSB_FIRST=1): ld=1 one cycle ->
  - so over the next 6 clocks = 0,1,0,1,0,1
  - busy=1 for 6 clocks; done=1 on the 6th edge; q=1010 throughout.
- DIV=2, d=0101, MSB_FIRST=0 -> so = 0,0,1,1,0,0,1,1,0,0,1,1; busy for 12 clocks; single done pulse.
- Ignored load: start a frame with 1111, assert ld with d=0000 at mid-frame and on the busy-clearing edge -> frame is all ones, q stays 1111. Next ld accepted one clock later loads 0000.
- Abort: assert clr during DATA of a 0000 frame -> so=1, busy=0, q=0000 asynchronously; no done pulse. A new ld after release starts a clean frame.
- Continuous ld with alternating d 1010/0101 -> two complete 6-clock frames with one idle clock (so=1) between them; two done pulses 7 clocks apart.
